// File: rtl/prco_uart_tx.sv
// Buffered 8N1 UART transmitter: byte writes land in a circular FIFO and are
// serialised LSB first onto q_tx, with back-to-back frames whenever data is waiting.
module prco_uart_tx #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned FIFO_LG = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_wr,
  input  logic [7:0] i_byte,
  output logic       q_tx,
  output logic       q_full,
  output logic       q_empty,
  output logic       q_busy,
  output logic       q_overflow
);

  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned Depth      = 1 << FIFO_LG;
  localparam logic [CntW-1:0]  CntMax  = CntW'(ClksPerBit - 1);
  localparam logic [FIFO_LG:0] CntFull = (FIFO_LG + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q;
  logic [7:0]         mem [Depth];
  logic [FIFO_LG-1:0] wptr_q, rptr_q;
  logic [FIFO_LG:0]   count_q, count_d;
  logic               full_q, empty_q, overflow_q;
  logic               tx_q, busy_q;
  logic [CntW-1:0]    baud_q;
  logic [2:0]         idx_q;
  logic [7:0]         shreg_q;
  logic               wr_ok, pop, bit_end;

  assign wr_ok   = i_wr & ~full_q;
  assign bit_end = (baud_q == CntMax);
  // A pop happens from IDLE or on the last STOP cycle, which gives gap-free frames.
  assign pop     = ~empty_q & ((state_q == StIdle) | ((state_q == StStop) & bit_end));

  always_comb begin
    count_d = count_q;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wptr_q] <= i_byte;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      if (i_wr && full_q) overflow_q <= 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CntFull);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          baud_q <= '0;
          if (pop) begin
            shreg_q <= mem[rptr_q];
            state_q <= StStart;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            baud_q  <= '0;
            idx_q   <= '0;
            state_q <= StData;
            tx_q    <= shreg_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_q <= '0;
            if (idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              shreg_q <= shreg_q >> 1;
              idx_q   <= idx_q + 1'b1;
              tx_q    <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_q <= '0;
            if (pop) begin
              shreg_q <= mem[rptr_q];
              state_q <= StStart;
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q_tx       = tx_q;
  assign q_full     = full_q;
  assign q_empty    = empty_q;
  assign q_busy     = busy_q;
  assign q_overflow = overflow_q;

endmodule

// File: tb/tb_prco_uart_tx.sv
// Bench for prco_uart_tx: frames are captured sample-by-sample from the line and
// compared against {stop, byte, start} patterns held ten cycles per bit.
module tb_prco_uart_tx;

  localparam int unsigned ClkHz = 1000;
  localparam int unsigned Baud  = 100;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] din   = 8'h00;
  logic       tx, full, empty, busy, ovf;

  int checks = 0;
  int errors = 0;

  prco_uart_tx #(
    .CLK_HZ (ClkHz),
    .BAUD   (Baud),
    .FIFO_LG(4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_wr      (wr),
    .i_byte    (din),
    .q_tx      (tx),
    .q_full    (full),
    .q_empty   (empty),
    .q_busy    (busy),
    .q_overflow(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr  = 1'b1;
    din = b;
    tick();
    wr  = 1'b0;
  endtask

  // Waits for a start bit, then records 100 consecutive line samples.
  task automatic capture_frame(input string name, input logic [9:0] line, input bit do_cmp,
                               input int exp_wait, input int max_wait,
                               output logic [9:0] mid);
    int          w = 0;
    logic [99:0] obs, rep, bsy;
    mid = '0;
    while (tx !== 1'b0 && w <= max_wait) begin
      tick();
      w++;
    end
    if (tx !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no start bit within %0d cycles", name, max_wait);
      return;
    end
    if (exp_wait >= 0) check({name, " latency"}, w, exp_wait);
    for (int k = 0; k < 100; k++) begin
      if (k > 0) tick();
      obs[k] = tx;
      bsy[k] = busy;
      if (k % 10 == 5) mid[k / 10] = tx;
    end
    for (int k = 0; k < 100; k++) rep[k] = mid[k / 10];
    check({name, " bit hold"}, obs, rep);
    check({name, " busy"}, bsy, {100{1'b1}});
    if (do_cmp) check({name, " mid-bit"}, mid, line);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  vec_t       vecs [5];
  logic [9:0] m0, m1, m2;
  logic [7:0] exp_q [$];
  logic [9:0] got_q [$];
  int         bad;

  initial begin
    // Line patterns in time order from bit 0: start 0, LSB-first data, stop 1.
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h3C, 10'b1001111000};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'h5A, 10'b1010110100};
    vecs[4] = '{8'hC3, 10'b1110000110};

    repeat (3) @(posedge clk);
    #1;
    check("rst tx", tx, 1'b1);
    check("rst empty", empty, 1'b1);
    check("rst full", full, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst overflow", ovf, 1'b0);
    rst_n = 1'b1;

    bad = 0;
    repeat (200) begin
      tick();
      if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || ovf !== 1'b0)
        bad++;
    end
    check("idle 200 cycles", bad, 0);

    for (int i = 0; i < 5; i++) begin
      fork
        write_byte(vecs[i].data);
        capture_frame($sformatf("vec%0d", i), vecs[i].line, 1'b1, 2, 20, m0);
      join
      tick();
      check($sformatf("vec%0d busy after", i), busy, 1'b0);
      check($sformatf("vec%0d empty after", i), empty, 1'b1);
    end

    fork
      begin
        write_byte(8'h01);
        write_byte(8'h80);
        write_byte(8'hFF);
      end
      begin
        capture_frame("burst0", 10'b1000000010, 1'b1, 2, 20, m0);
        capture_frame("burst1", 10'b1100000000, 1'b1, 1, 5, m1);
        capture_frame("burst2", 10'b1111111110, 1'b1, 1, 5, m2);
      end
    join
    tick();
    check("burst busy after", busy, 1'b0);
    check("burst empty after", empty, 1'b1);

    // Write lands on the last STOP cycle: FSM must idle one cycle, then start.
    fork
      write_byte(8'h5A);
      capture_frame("stopwr0", 10'b1010110100, 1'b1, 2, 20, m0);
    join
    write_byte(8'h96);
    check("stopwr tx idle", tx, 1'b1);
    check("stopwr busy", busy, 1'b0);
    check("stopwr empty", empty, 1'b0);
    capture_frame("stopwr1", 10'b1100101100, 1'b1, 1, 5, m1);
    tick();
    check("stopwr busy after", busy, 1'b0);

    fork
      begin
        for (int b = 0; b < 19; b++) begin
          write_byte(8'(b));
          if (b == 15) check("fill full at 15", full, 1'b0);
          if (b == 16) begin
            check("fill full at 16", full, 1'b1);
            check("fill ovf at 16", ovf, 1'b0);
          end
          if (b == 17) check("fill ovf at 17", ovf, 1'b1);
        end
      end
      begin
        for (int i = 0; i < 17; i++)
          capture_frame($sformatf("fill%0d", i), {1'b1, 8'(i), 1'b0}, 1'b1,
                        (i == 0) ? 2 : 1, 20, m0);
      end
    join
    tick();
    check("fill drained empty", empty, 1'b1);
    check("fill drained full", full, 1'b0);
    check("fill ovf sticky", ovf, 1'b1);
    check("fill busy after", busy, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(3, 10));
      exp_q.delete();
      got_q.delete();
      fork
        for (int j = 0; j < n; j++) begin
          logic [7:0] b;
          repeat ($urandom_range(0, 30)) tick();
          b = 8'($urandom);
          exp_q.push_back(b);
          write_byte(b);
        end
        for (int j = 0; j < n; j++) begin
          logic [9:0] g;
          capture_frame($sformatf("rnd%0d.%0d", r, j), 10'h0, 1'b0, -1, 40, g);
          got_q.push_back(g);
        end
      join
      for (int j = 0; j < n; j++)
        check($sformatf("rnd%0d.%0d byte", r, j), got_q[j], {1'b1, exp_q[j], 1'b0});
      tick();
      check($sformatf("rnd%0d busy after", r), busy, 1'b0);
    end

    write_byte(8'h3C);
    write_byte(8'h11);
    write_byte(8'h22);
    check("rstmid start", tx, 1'b0);
    repeat (24) tick();
    check("rstmid data bit1", tx, 1'b0);
    repeat (20) tick();
    check("rstmid data bit3", tx, 1'b1);
    check("rstmid busy", busy, 1'b1);
    check("rstmid queued", empty, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstmid async tx", tx, 1'b1);
    check("rstmid async busy", busy, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rstmid empty", empty, 1'b1);
    check("rstmid busy after", busy, 1'b0);
    check("rstmid full", full, 1'b0);
    check("rstmid ovf cleared", ovf, 1'b0);
    bad = 0;
    repeat (300) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("rstmid no frames", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
